scan_word_mux: RTL and testbench

Parametrised, registered successor to the 64-bit, 32-way word selector used on the register/voice read path. Selects one of NUM_WORDS words of WIDTH bits and presents it through a valid/ready output register. Two modes: single reads on request, or an automatic scan that streams every word in index order, for voice-table dumps and display refresh. Sits between the word storage and any consumer that can stall.

---
 rtl/scan_word_mux_pkg.sv | 10 +
 rtl/scan_word_mux_word_sel.sv | 32 +++
 rtl/scan_word_mux.sv | 111 +++++++++++
 tb/tb_scan_word_mux.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_word_mux_pkg.sv
// scan_word_mux_pkg: shared types for the scan_word_mux read-path selector.
//   state_t : controller state (IDLE = single reads / waiting, SCAN = streaming words)
package scan_word_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage : scan_word_mux_pkg

// File: rtl/scan_word_mux_word_sel.sv
// scan_word_mux_word_sel: combinational NUM_WORDS:1 word selector.
//   i_words : word array, word-major (i_words[k] is word k)
//   i_sel   : word index
//   o_data  : selected word, zero when i_sel is out of range
//   o_err   : high when i_sel >= NUM_WORDS
module scan_word_mux_word_sel
    import scan_word_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned NUM_WORDS = 32,
    localparam int unsigned SEL_W    = $clog2(NUM_WORDS)
) (
    input  logic [NUM_WORDS-1:0][WIDTH-1:0] i_words,
    input  logic [SEL_W-1:0]                i_sel,
    output logic [WIDTH-1:0]                o_data,
    output logic                            o_err
);

    // Compare against each legal index so an out-of-range select falls
    // through to zero data instead of an undefined array read.
    always_comb begin
        o_data = '0;
        o_err  = 1'b1;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_words[k];
                o_err  = 1'b0;
            end
        end
    end

endmodule : scan_word_mux_word_sel

// File: rtl/scan_word_mux.sv
// scan_word_mux: registered NUM_WORDS-way word selector with single-read and
// scan modes, presented through a one-entry valid/ready output register.
//   clk, reset            : clock, asynchronous active-high reset
//   in                    : word array (in[k] is word k)
//   mode                  : 0 single read, 1 scan (sampled at request acceptance)
//   req_valid/req_ready   : request handshake, req_sel = index / scan start
//   out_valid/out_ready   : output handshake
//   out_data/out_sel      : selected word and its index
//   out_err               : request index out of range (out_data = 0)
//   scan_done             : marks the final beat of a scan
module scan_word_mux
    import scan_word_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned NUM_WORDS = 32,
    localparam int unsigned SEL_W    = $clog2(NUM_WORDS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WORDS-1:0][WIDTH-1:0] in,
    input  logic                            mode,
    input  logic                            req_valid,
    input  logic [SEL_W-1:0]                req_sel,
    output logic                            req_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [SEL_W-1:0]                out_sel,
    output logic                            out_err,
    output logic                            scan_done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WORDS - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_index;

    logic             w_free;
    logic [SEL_W-1:0] w_sel;
    logic [WIDTH-1:0] w_data;
    logic             w_err;
    logic             w_start_scan;

    // Output register can take a new beat when empty or drained this cycle.
    assign w_free    = !out_valid || out_ready;
    assign req_ready = (r_state == IDLE) && w_free;

    // The scan counter drives the selector while scanning, the request otherwise.
    assign w_sel = (r_state == SCAN) ? r_index : req_sel;

    // A scan starting on the last word is a single beat and never enters SCAN.
    assign w_start_scan = mode && !w_err && (req_sel != LAST_SEL);

    scan_word_mux_word_sel #(
        .WIDTH     (WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_word_sel (
        .i_words (in),
        .i_sel   (w_sel),
        .o_data  (w_data),
        .o_err   (w_err)
    );

    // Controller, scan index and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_index   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && w_free) begin
                        out_valid <= 1'b1;
                        out_data  <= w_data;
                        out_sel   <= req_sel;
                        out_err   <= w_err;
                        scan_done <= mode && !w_err && (req_sel == LAST_SEL);
                        if (w_start_scan) begin
                            r_state <= SCAN;
                            r_index <= req_sel + SEL_W'(1);
                        end
                    end else if (w_free) begin
                        out_valid <= 1'b0;
                        scan_done <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_free) begin
                        out_valid <= 1'b1;
                        out_data  <= w_data;
                        out_sel   <= r_index;
                        out_err   <= 1'b0;
                        scan_done <= (r_index == LAST_SEL);
                        if (r_index == LAST_SEL) begin
                            r_state <= IDLE;
                        end else begin
                            r_index <= r_index + SEL_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : scan_word_mux

// File: tb/tb_scan_word_mux.sv
module tb_scan_word_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default configuration: 64-bit x 32 words
    logic [31:0][63:0] in_a;
    logic              mode, req_valid, req_ready, out_valid, out_ready;
    logic [4:0]        req_sel, out_sel;
    logic [63:0]       out_data;
    logic              out_err, scan_done;

    scan_word_mux #(.WIDTH(64), .NUM_WORDS(32)) dut (
        .clk(clk), .reset(reset), .in(in_a), .mode(mode),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_err(out_err), .scan_done(scan_done)
    );

    // Non-power-of-two configuration: 64-bit x 20 words
    logic [19:0][63:0] in_b;
    logic              b_mode, b_req_valid, b_req_ready, b_out_valid, b_out_ready;
    logic [4:0]        b_req_sel, b_out_sel;
    logic [63:0]       b_out_data;
    logic              b_out_err, b_scan_done;

    scan_word_mux #(.WIDTH(64), .NUM_WORDS(20)) dut20 (
        .clk(clk), .reset(reset), .in(in_b), .mode(b_mode),
        .req_valid(b_req_valid), .req_sel(b_req_sel), .req_ready(b_req_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_err(b_out_err), .scan_done(b_scan_done)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        mode;
        logic [4:0]  sel;
        logic [63:0] exp_data;
        logic        exp_done;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [63:0] word_of(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request on the falling edge, confirm it is acceptable,
    // let the rising edge take it, then withdraw it.
    task automatic drive(input logic m, input logic [4:0] s, input logic ordy);
        @(negedge clk);
        mode      = m;
        req_sel   = s;
        out_ready = ordy;
        req_valid = 1'b1;
        chk("req_ready_at_request", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{mode: 1'b0, sel: 5'd5,  exp_data: 64'h0505_0505_0505_0505, exp_done: 1'b0};
        vecs[1] = '{mode: 1'b0, sel: 5'd31, exp_data: 64'h1F1F_1F1F_1F1F_1F1F, exp_done: 1'b0};
        vecs[2] = '{mode: 1'b0, sel: 5'd0,  exp_data: 64'h0000_0000_0000_0000, exp_done: 1'b0};
        vecs[3] = '{mode: 1'b1, sel: 5'd31, exp_data: 64'h1F1F_1F1F_1F1F_1F1F, exp_done: 1'b1};

        for (int k = 0; k < 32; k++) in_a[k] = word_of(k);
        for (int k = 0; k < 20; k++) in_b[k] = word_of(k);
        reset = 1'b1;
        mode = 1'b0; req_valid = 1'b0; req_sel = '0; out_ready = 1'b0;
        b_mode = 1'b0; b_req_valid = 1'b0; b_req_sel = '0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_out_sel",   64'(out_sel),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_scan_done", 64'(scan_done), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // Table of single-beat requests
        for (int v = 0; v < 4; v++) begin
            drive(vecs[v].mode, vecs[v].sel, 1'b1);
            @(negedge clk);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_data",  out_data,       vecs[v].exp_data);
            chk("vec_sel",   64'(out_sel),   64'(vecs[v].sel));
            chk("vec_err",   64'(out_err),   64'd0);
            chk("vec_done",  64'(scan_done), 64'(vecs[v].exp_done));
        end
        @(negedge clk);
        chk("vec_drained", 64'(out_valid), 64'd0);

        // Back-to-back single reads: second request accepted while first is consumed
        @(negedge clk);
        mode = 1'b0; req_sel = 5'd5; req_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 req_sel = 5'd6;
        @(negedge clk);
        chk("b2b_first_sel", 64'(out_sel),   64'd5);
        chk("b2b_ready",     64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_sel",  64'(out_sel), 64'd6);
        chk("b2b_second_data", out_data,     word_of(6));
        @(negedge clk);

        // Full scan from 0
        drive(1'b1, 5'd0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("scan_valid", 64'(out_valid), 64'd1);
            chk("scan_sel",   64'(out_sel),   64'(i));
            chk("scan_data",  out_data,       word_of(i));
            chk("scan_done",  64'(scan_done), (i == 31) ? 64'd1 : 64'd0);
            if (i < 31) chk("scan_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        chk("scan_end_valid", 64'(out_valid), 64'd0);
        chk("scan_end_ready", 64'(req_ready), 64'd1);

        // Back-pressure: scan from 28, stall 3 cycles on sel 29
        drive(1'b1, 5'd28, 1'b1);
        @(negedge clk);
        chk("bp_sel28", 64'(out_sel), 64'd28);
        @(negedge clk);
        chk("bp_sel29", 64'(out_sel), 64'd29);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_sel",   64'(out_sel),   64'd29);
            chk("bp_hold_data",  out_data,       word_of(29));
            chk("bp_hold_done",  64'(scan_done), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_sel30",  64'(out_sel),   64'd30);
        chk("bp_done30", 64'(scan_done), 64'd0);
        @(negedge clk);
        chk("bp_sel31",  64'(out_sel),   64'd31);
        chk("bp_data31", out_data,       word_of(31));
        chk("bp_done31", 64'(scan_done), 64'd1);
        @(negedge clk);
        chk("bp_end_valid", 64'(out_valid), 64'd0);

        // Input change while stalled on a held beat
        drive(1'b0, 5'd7, 1'b0);
        @(negedge clk);
        chk("stall_data", out_data, 64'h0707_0707_0707_0707);
        in_a[7] = 64'd0;
        repeat (2) @(negedge clk);
        chk("stall_held_data", out_data,       64'h0707_0707_0707_0707);
        chk("stall_held_valid", 64'(out_valid), 64'd1);
        in_a[7] = word_of(7);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Reset in the middle of a scan
        drive(1'b1, 5'd0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_sel10", 64'(out_sel), 64'd10);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_done",  64'(scan_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
            chk("post_rst_done",  64'(scan_done), 64'd0);
        end
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        drive(1'b0, 5'd3, 1'b1);
        @(negedge clk);
        chk("post_rst_data", out_data,     64'h0303_0303_0303_0303);
        chk("post_rst_sel",  64'(out_sel), 64'd3);

        // Out-of-range request on the 20-word instance (scan must not start)
        @(negedge clk);
        b_mode = 1'b1; b_req_sel = 5'd25; b_req_valid = 1'b1; b_out_ready = 1'b1;
        chk("oor_req_ready", 64'(b_req_ready), 64'd1);
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("oor_valid", 64'(b_out_valid), 64'd1);
        chk("oor_data",  b_out_data,       64'd0);
        chk("oor_err",   64'(b_out_err),   64'd1);
        chk("oor_sel",   64'(b_out_sel),   64'd25);
        chk("oor_done",  64'(b_scan_done), 64'd0);
        @(negedge clk);
        chk("oor_no_scan", 64'(b_out_valid), 64'd0);
        chk("oor_idle",    64'(b_req_ready), 64'd1);

        // Scan to the last word of the 20-word instance
        b_req_sel = 5'd18; b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("w20_sel18",  64'(b_out_sel),   64'd18);
        chk("w20_done18", 64'(b_scan_done), 64'd0);
        chk("w20_busy",   64'(b_req_ready), 64'd0);
        @(negedge clk);
        chk("w20_sel19",  64'(b_out_sel),   64'd19);
        chk("w20_data19", b_out_data,       word_of(19));
        chk("w20_err19",  64'(b_out_err),   64'd0);
        chk("w20_done19", 64'(b_scan_done), 64'd1);
        @(negedge clk);
        chk("w20_no_wrap", 64'(b_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scan_word_mux
